// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Four-way register-file write-back arbiter with a single
//               registered output stage. Holds the stage while stall=1.
//               Define WB_ARB_ROUND_ROBIN_EN to select round-robin
//               arbitration. Otherwise it uses fixed priority (ALU highest).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [3:0]   req,
    input  logic [11:0]  req_code,
    input  logic [127:0] req_data,
    output logic [3:0]   ack,
    input  logic         stall,
    output logic [2:0]   RegDst,
    output logic [31:0]  wb_data,
    output logic         RegWrite,
    output logic [1:0]   wb_src,
    output logic         code_err
);

    localparam logic [2:0] C_MAX_LEGAL_CODE = 3'd4;

    logic        w_free;
    logic        w_found;
    logic [1:0]  w_idx;
    logic [1:0]  w_cand;
    logic [2:0]  w_code;
    logic [31:0] w_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [1:0]  r_ptr;
`endif

    // A valid output blocked by stall is the only condition that freezes the stage.
    assign w_free = ~RegWrite | ~stall;

    always_comb begin
        w_found = 1'b0;
        w_idx   = 2'd0;
        w_cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            w_cand = r_ptr + 2'(k);
`else
            w_cand = 2'(k);
`endif
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_code = 3'd0;
        w_data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_idx == 2'(i)) begin
                w_code = req_code[3*i +: 3];
                w_data = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        ack = 4'b0000;
        if (reset_n && w_free && w_found) begin
            ack[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite <= 1'b0;
            RegDst   <= 3'd0;
            wb_data  <= 32'd0;
            wb_src   <= 2'd0;
            code_err <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            r_ptr    <= 2'd0;
`endif
        end else if (w_free) begin
            if (w_found) begin
                if (w_code <= C_MAX_LEGAL_CODE) begin
                    RegWrite <= 1'b1;
                    RegDst   <= w_code;
                    wb_data  <= w_data;
                    wb_src   <= w_idx;
                end else begin
                    // Illegal code: consume the request but never write it.
                    RegWrite <= 1'b0;
                    code_err <= 1'b1;
                end
`ifdef WB_ARB_ROUND_ROBIN_EN
                r_ptr <= w_idx + 2'd1;
`endif
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
